// File: rtl/matrix_fill_pkg.sv
// matrix_fill_pkg
//   Shared types and constants for the matrix_fill generator:
//   - fill_mode_e  : element fill mode as presented on the mode input
//   - fill_state_e : generator FSM state encoding
//   - LFSR_TAPS / LFSR_DEFAULT_SEED : 16-bit Fibonacci LFSR definition
//   - lfsr_next()  : one LFSR step (shift left, feedback into bit 0)
package matrix_fill_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM   = 2'd0,
    MODE_ZERO     = 2'd1,
    MODE_IDENTITY = 2'd2,
    MODE_CONST    = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE_DIM = 2'd1,
    ST_FILL      = 2'd2
  } fill_state_e;

  // Taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/matrix_lfsr.sv
// matrix_lfsr
//   16-bit Fibonacci LFSR register used as the random element source.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//     adv        : advance one step on the next edge
//     load       : load seed_in on the next edge (a zero seed loads SEED,
//                  since the all-zero state would lock the LFSR)
//     seed_in    : value for load
//     state      : current register value
module matrix_lfsr
  import matrix_fill_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        load,
  input  logic [15:0] seed_in,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed_in == 16'h0000) ? SEED : seed_in;
    end else if (adv) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/matrix_fill.sv
// matrix_fill
//   Fills a matrix slot: on an accepted start it writes the dimensions
//   once, then every element in row-major order (one per cycle) using the
//   selected fill mode (RANDOM / ZERO / IDENTITY / CONST).
//   Optional feature macro: MATRIX_FILL_SEED_LOAD_EN adds seed_we/seed_in
//   so the LFSR can be reseeded while idle.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     start, abort         : job request (sampled in IDLE) / cancel
//     mode, target_m/n,
//     target_slot,
//     rand_bits, fill_val  : job parameters, latched at start
//     seed_we, seed_in     : LFSR reseed (only with the macro defined)
//     gen_slot_idx, gen_row, gen_col, gen_data, gen_we : element write
//     gen_dim_m, gen_dim_n, gen_dim_we                 : dimension write
//     busy, done, err      : status
module matrix_fill
  import matrix_fill_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          DIM_W     = 3,
  parameter int          SLOT_W    = 2,
  parameter int          MAX_DIM   = 5,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  target_m,
  input  logic [DIM_W-1:0]  target_n,
  input  logic [SLOT_W-1:0] target_slot,
  input  logic [4:0]        rand_bits,
  input  logic [DATA_W-1:0] fill_val,
`ifdef MATRIX_FILL_SEED_LOAD_EN
  input  logic              seed_we,
  input  logic [15:0]       seed_in,
`endif
  output logic [SLOT_W-1:0] gen_slot_idx,
  output logic [DIM_W-1:0]  gen_row,
  output logic [DIM_W-1:0]  gen_col,
  output logic [DATA_W-1:0] gen_data,
  output logic              gen_we,
  output logic [DIM_W-1:0]  gen_dim_m,
  output logic [DIM_W-1:0]  gen_dim_n,
  output logic              gen_dim_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DIM_W-1:0] MAX_DIM_L = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [4:0]       DATA_W_5  = 5'(DATA_W);

  // Saturate the requested random width into 1..DATA_W.
  function automatic logic [4:0] clamp_rand_bits(input logic [4:0] rb);
    if (rb == 5'd0) begin
      return 5'd1;
    end else if (rb > DATA_W_5) begin
      return DATA_W_5;
    end else begin
      return rb;
    end
  endfunction

  // FSM and job context
  fill_state_e       state_q, state_d;
  fill_mode_e        mode_q, mode_d;
  logic [DIM_W-1:0]  m_q, m_d;
  logic [DIM_W-1:0]  n_q, n_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [4:0]        rb_q, rb_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DIM_W-1:0]  cur_row_q, cur_row_d;
  logic [DIM_W-1:0]  cur_col_q, cur_col_d;

  // Registered outputs
  logic [SLOT_W-1:0] gen_slot_idx_q, gen_slot_idx_d;
  logic [DIM_W-1:0]  gen_row_q, gen_row_d;
  logic [DIM_W-1:0]  gen_col_q, gen_col_d;
  logic [DATA_W-1:0] gen_data_q, gen_data_d;
  logic              gen_we_q, gen_we_d;
  logic [DIM_W-1:0]  gen_dim_m_q, gen_dim_m_d;
  logic [DIM_W-1:0]  gen_dim_n_q, gen_dim_n_d;
  logic              gen_dim_we_q, gen_dim_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // LFSR interface
  logic [15:0] lfsr_state;
  logic        lfsr_adv;
  logic        lfsr_load;
  logic [15:0] lfsr_seed;

`ifdef MATRIX_FILL_SEED_LOAD_EN
  // Reseeding is only honoured while idle so a running job keeps its sequence.
  assign lfsr_load = (state_q == ST_IDLE) && seed_we;
  assign lfsr_seed = seed_in;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = 16'h0000;
`endif

  matrix_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (lfsr_adv),
    .load    (lfsr_load),
    .seed_in (lfsr_seed),
    .state   (lfsr_state)
  );

  // Element value for the current cursor position
  logic              dims_ok;
  logic              last_elem;
  logic [15:0]       rand_mask;
  logic [15:0]       rand_val;
  logic [DATA_W-1:0] elem_data;

  assign dims_ok = (target_m != '0) && (target_n != '0) &&
                   (target_m <= MAX_DIM_L) && (target_n <= MAX_DIM_L);

  assign last_elem = (cur_row_q == (m_q - DIM_ONE)) && (cur_col_q == (n_q - DIM_ONE));

  // rb_q of 16 shifts the one out entirely; the subtraction then wraps to all ones.
  assign rand_mask = (16'd1 << rb_q) - 16'd1;
  assign rand_val  = lfsr_state & rand_mask;

  always_comb begin
    elem_data = '0;
    case (mode_q)
      MODE_RANDOM:   elem_data = rand_val[DATA_W-1:0];
      MODE_ZERO:     elem_data = '0;
      MODE_IDENTITY: elem_data = (cur_row_q == cur_col_q) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      MODE_CONST:    elem_data = fill_q;
      default:       elem_data = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    m_d            = m_q;
    n_d            = n_q;
    slot_d         = slot_q;
    rb_d           = rb_q;
    fill_d         = fill_q;
    cur_row_d      = cur_row_q;
    cur_col_d      = cur_col_q;
    gen_slot_idx_d = gen_slot_idx_q;
    gen_row_d      = gen_row_q;
    gen_col_d      = gen_col_q;
    gen_data_d     = gen_data_q;
    gen_dim_m_d    = gen_dim_m_q;
    gen_dim_n_d    = gen_dim_n_q;
    busy_d         = busy_q;
    gen_we_d       = 1'b0;
    gen_dim_we_d   = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    lfsr_adv       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (dims_ok) begin
            state_d = ST_WRITE_DIM;
            mode_d  = fill_mode_e'(mode);
            m_d     = target_m;
            n_d     = target_n;
            slot_d  = target_slot;
            rb_d    = clamp_rand_bits(rand_bits);
            fill_d  = fill_val;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WRITE_DIM: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gen_dim_we_d   = 1'b1;
          gen_dim_m_d    = m_q;
          gen_dim_n_d    = n_q;
          gen_slot_idx_d = slot_q;
          cur_row_d      = '0;
          cur_col_d      = '0;
          state_d        = ST_FILL;
        end
      end

      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gen_we_d       = 1'b1;
          gen_row_d      = cur_row_q;
          gen_col_d      = cur_col_q;
          gen_data_d     = elem_data;
          gen_slot_idx_d = slot_q;
          lfsr_adv       = (mode_q == MODE_RANDOM);
          if (last_elem) begin
            // busy stays high through the done cycle; IDLE drops it next edge.
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cur_col_q == (n_q - DIM_ONE)) begin
            cur_col_d = '0;
            cur_row_d = cur_row_q + DIM_ONE;
          end else begin
            cur_col_d = cur_col_q + DIM_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_RANDOM;
      m_q            <= '0;
      n_q            <= '0;
      slot_q         <= '0;
      rb_q           <= 5'd1;
      fill_q         <= '0;
      cur_row_q      <= '0;
      cur_col_q      <= '0;
      gen_slot_idx_q <= '0;
      gen_row_q      <= '0;
      gen_col_q      <= '0;
      gen_data_q     <= '0;
      gen_we_q       <= 1'b0;
      gen_dim_m_q    <= '0;
      gen_dim_n_q    <= '0;
      gen_dim_we_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      m_q            <= m_d;
      n_q            <= n_d;
      slot_q         <= slot_d;
      rb_q           <= rb_d;
      fill_q         <= fill_d;
      cur_row_q      <= cur_row_d;
      cur_col_q      <= cur_col_d;
      gen_slot_idx_q <= gen_slot_idx_d;
      gen_row_q      <= gen_row_d;
      gen_col_q      <= gen_col_d;
      gen_data_q     <= gen_data_d;
      gen_we_q       <= gen_we_d;
      gen_dim_m_q    <= gen_dim_m_d;
      gen_dim_n_q    <= gen_dim_n_d;
      gen_dim_we_q   <= gen_dim_we_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign gen_slot_idx = gen_slot_idx_q;
  assign gen_row      = gen_row_q;
  assign gen_col      = gen_col_q;
  assign gen_data     = gen_data_q;
  assign gen_we       = gen_we_q;
  assign gen_dim_m    = gen_dim_m_q;
  assign gen_dim_n    = gen_dim_n_q;
  assign gen_dim_we   = gen_dim_we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_matrix_fill.sv
// tb_matrix_fill
//   Self-checking bench for matrix_fill (default parameters). A reference
//   model computes the expected write sequence for each job from the fill
//   rules and an arithmetic LFSR; jobs come from a vector table, a few
//   hand-written corner sequences and a randomized loop.
module tb_matrix_fill;

  localparam int DATA_W  = 16;
  localparam int DIM_W   = 3;
  localparam int SLOT_W  = 2;
  localparam int MAX_DIM = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DIM_W-1:0]  target_m;
  logic [DIM_W-1:0]  target_n;
  logic [SLOT_W-1:0] target_slot;
  logic [4:0]        rand_bits;
  logic [DATA_W-1:0] fill_val;
`ifdef MATRIX_FILL_SEED_LOAD_EN
  logic              seed_we;
  logic [15:0]       seed_in;
`endif
  logic [SLOT_W-1:0] gen_slot_idx;
  logic [DIM_W-1:0]  gen_row;
  logic [DIM_W-1:0]  gen_col;
  logic [DATA_W-1:0] gen_data;
  logic              gen_we;
  logic [DIM_W-1:0]  gen_dim_m;
  logic [DIM_W-1:0]  gen_dim_n;
  logic              gen_dim_we;
  logic              busy;
  logic              done;
  logic              err;

  matrix_fill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .target_m     (target_m),
    .target_n     (target_n),
    .target_slot  (target_slot),
    .rand_bits    (rand_bits),
    .fill_val     (fill_val),
`ifdef MATRIX_FILL_SEED_LOAD_EN
    .seed_we      (seed_we),
    .seed_in      (seed_in),
`endif
    .gen_slot_idx (gen_slot_idx),
    .gen_row      (gen_row),
    .gen_col      (gen_col),
    .gen_data     (gen_data),
    .gen_we       (gen_we),
    .gen_dim_m    (gen_dim_m),
    .gen_dim_n    (gen_dim_n),
    .gen_dim_we   (gen_dim_we),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl_lfsr;
  logic [15:0] wr_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Spec-level LFSR step: feedback = b15^b13^b12^b10, shift left into bit 0.
  function automatic logic [15:0] mdl_step(input logic [15:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v * 2) + fb) % 65536);
  endfunction

  function automatic int mdl_elem(input logic [1:0] md, input int r, input int c,
                                  input int rb, input logic [15:0] fv);
    int rbc;
    case (md)
      2'd0: begin
        rbc = (rb == 0) ? 1 : ((rb > DATA_W) ? DATA_W : rb);
        return int'(mdl_lfsr) % (1 << rbc);
      end
      2'd1:    return 0;
      2'd2:    return (r == c) ? 1 : 0;
      default: return int'(fv);
    endcase
  endfunction

  // Runs one job and checks every cycle. abort_at = edge index (E0 = accept)
  // at which abort is sampled high; 0 means no abort.
  task automatic run_job(input logic [1:0] md, input int m, input int n, input int slot,
                         input int rb, input logic [15:0] fv, input int abort_at,
                         output int nwr);
    bit legal;
    bit aborted;
    int nel;
    int k;
    int ed;
    legal   = (m >= 1) && (m <= MAX_DIM) && (n >= 1) && (n <= MAX_DIM);
    nel     = m * n;
    nwr     = 0;
    aborted = 0;
    wr_data.delete();
    @(negedge clk);
    mode        = md;
    target_m    = DIM_W'(m);
    target_n    = DIM_W'(n);
    target_slot = SLOT_W'(slot);
    rand_bits   = 5'(rb);
    fill_val    = fv;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!legal) begin
      chk("illegal_err", err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_dimwe", gen_dim_we, 0);
      chk("illegal_we", gen_we, 0);
      @(posedge clk); #1;
      chk("illegal_err_pulse", err, 0);
      chk("illegal_busy2", busy, 0);
      chk("illegal_we2", gen_we | gen_dim_we, 0);
      return;
    end
    chk("accept_busy", busy, 1);
    chk("accept_err", err, 0);
    chk("accept_dimwe", gen_dim_we, 0);
    for (int j = 1; j <= nel + 1; j++) begin
      if (j == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      if (j == abort_at) begin
        abort = 1'b0;
        chk("abort_we", gen_we, 0);
        chk("abort_dimwe", gen_dim_we, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_busy", busy, 0);
        aborted = 1;
        break;
      end
      if (j == 1) begin
        chk("dim_we", gen_dim_we, 1);
        chk("dim_m", gen_dim_m, m);
        chk("dim_n", gen_dim_n, n);
        chk("dim_slot", gen_slot_idx, slot);
        chk("dim_phase_we", gen_we, 0);
        chk("dim_phase_busy", busy, 1);
      end else begin
        k = j - 2;
        ed = mdl_elem(md, k / n, k % n, rb, fv);
        wr_data.push_back(gen_data);
        chk("elem_we", gen_we, 1);
        chk("elem_row", gen_row, k / n);
        chk("elem_col", gen_col, k % n);
        chk("elem_data", gen_data, ed);
        chk("elem_slot", gen_slot_idx, slot);
        chk("elem_done", done, (k == nel - 1) ? 1 : 0);
        chk("elem_busy", busy, 1);
        chk("elem_dimwe", gen_dim_we, 0);
        if (md == 2'd0) mdl_lfsr = mdl_step(mdl_lfsr);
        nwr++;
      end
    end
    @(posedge clk); #1;
    chk("after_busy", busy, 0);
    chk("after_we", gen_we, 0);
    chk("after_done", done, 0);
    if (aborted) chk("after_abort_dimwe", gen_dim_we, 0);
  endtask

  typedef struct {
    logic [1:0]  md;
    int          m;
    int          n;
    int          slot;
    int          rb;
    logic [15:0] fv;
    int          abort_at;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int nw;
    vec_t v;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    target_m = '0; target_n = '0; target_slot = '0; rand_bits = '0; fill_val = '0;
`ifdef MATRIX_FILL_SEED_LOAD_EN
    seed_we = 1'b0; seed_in = '0;
`endif
    mdl_lfsr = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", gen_we, 0);
    chk("rst_dimwe", gen_dim_we, 0);
    chk("rst_data", gen_data, 0);
    chk("rst_rowcol", {gen_row, gen_col, gen_slot_idx}, 0);
    chk("rst_dims", {gen_dim_m, gen_dim_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RANDOM 2x2 after reset: known first two values.
    run_job(2'd0, 2, 2, 1, 4, 16'h0, 0, nw);
    chk("r22_count", nw, 4);
    chk("r22_w0", wr_data[0], 16'h1);
    chk("r22_w1", wr_data[1], 16'h3);

    vecs.push_back('{2'd2, 3, 3, 2, 4,  16'h0000, 0, 9});
    vecs.push_back('{2'd0, 0, 3, 0, 4,  16'h0000, 0, 0});
    vecs.push_back('{2'd0, 2, 6, 0, 4,  16'h0000, 0, 0});
    vecs.push_back('{2'd3, 5, 5, 3, 4,  16'hBEEF, 5, 3});
    vecs.push_back('{2'd1, 1, 5, 1, 4,  16'hFFFF, 0, 5});
    vecs.push_back('{2'd0, 3, 2, 0, 0,  16'h0000, 0, 6});
    vecs.push_back('{2'd0, 1, 3, 2, 20, 16'h0000, 0, 3});
    vecs.push_back('{2'd3, 4, 1, 3, 4,  16'h1234, 0, 4});
    vecs.push_back('{2'd0, 2, 2, 1, 8,  16'h0000, 1, 0});
    vecs.push_back('{2'd2, 5, 5, 0, 4,  16'h0000, 3, 1});
    vecs.push_back('{2'd0, 5, 5, 2, 16, 16'h0000, 0, 25});
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_job(v.md, v.m, v.n, v.slot, v.rb, v.fv, v.abort_at, nw);
      chk($sformatf("vec%0d_writes", i), nw, v.exp_wr);
    end

    // start held high across done: a new job starts right after.
    @(negedge clk);
    mode = 2'd1; target_m = 3'd1; target_n = 3'd1; target_slot = 2'd0; start = 1'b1;
    @(posedge clk); #1; chk("hold_busy0", busy, 1);
    @(posedge clk); #1; chk("hold_dimwe1", gen_dim_we, 1);
    @(posedge clk); #1; chk("hold_done1", {gen_we, done}, 2'b11);
    @(posedge clk); #1; chk("hold_reaccept", {busy, gen_we}, 2'b10);
    @(posedge clk); #1; chk("hold_dimwe2", gen_dim_we, 1);
    start = 1'b0;
    @(posedge clk); #1; chk("hold_done2", {gen_we, done}, 2'b11);
    @(posedge clk); #1; chk("hold_idle", busy, 0);

    // abort while idle has no effect on the following job.
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; chk("idle_abort_busy", busy, 0);
    @(negedge clk); abort = 1'b0;
    run_job(2'd3, 1, 2, 1, 4, 16'h00A5, 0, nw);
    chk("post_idle_abort_writes", nw, 2);

    // Reset in the middle of a RANDOM job.
    @(negedge clk);
    mode = 2'd0; target_m = 3'd3; target_n = 3'd3; rand_bits = 5'd4; target_slot = 2'd3;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", gen_we, 0);
    chk("midrst_data", gen_data, 0);
    chk("midrst_pos", {gen_row, gen_col, gen_slot_idx}, 0);
    chk("midrst_dims", {gen_dim_m, gen_dim_n, gen_dim_we}, 0);
    @(negedge clk); rst_n = 1'b1;
    mdl_lfsr = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_quiet", {busy, gen_we, gen_dim_we, done}, 0);
    end
    run_job(2'd0, 1, 1, 0, 4, 16'h0, 0, nw);
    chk("postrst_first", wr_data[0], 16'h1);

`ifdef MATRIX_FILL_SEED_LOAD_EN
    @(negedge clk); seed_we = 1'b1; seed_in = 16'h0000;
    @(negedge clk); seed_we = 1'b0;
    mdl_lfsr = 16'hACE1;
    run_job(2'd0, 1, 1, 0, 4, 16'h0, 0, nw);
    chk("seed0_val", wr_data[0], 16'h1);
    @(negedge clk); seed_we = 1'b1; seed_in = 16'h0002;
    @(negedge clk); seed_we = 1'b0;
    mdl_lfsr = 16'h0002;
    run_job(2'd0, 1, 1, 0, 4, 16'h0, 0, nw);
    chk("seed2_val", wr_data[0], 16'h2);
`endif

    // Randomized jobs against the model.
    for (int i = 0; i < 25; i++) begin
      int rm;
      int rn;
      int ab;
      rm = $urandom_range(0, 6);
      rn = $urandom_range(0, 6);
      ab = 0;
      if (($urandom_range(0, 3) == 0) && (rm * rn > 0))
        ab = $urandom_range(1, rm * rn + 1);
      run_job(2'($urandom_range(0, 3)), rm, rn, $urandom_range(0, 3),
              $urandom_range(0, 20), 16'($urandom), ab, nw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_fill.md
MATRIX_FILL -- requirements
Module: matrix_fill

Interface
REQ-001 SHALL have parameter DATA_W, default 16: element width, legal range 4..16.
REQ-002 SHALL have parameter DIM_W, default 3: dimension and index width.
REQ-003 SHALL have parameter SLOT_W, default 2: slot index width.
REQ-004 SHALL have parameter MAX_DIM, default 5: largest legal m or n, at most 2^DIM_W-1.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1: reset seed, non-zero.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-008 start  in  1  request; sampled only in IDLE.
REQ-009 abort  in  1  cancel the job in progress.
REQ-010 mode  in  2  fill mode: 0 RANDOM, 1 ZERO, 2 IDENTITY, 3 CONST.
REQ-011 target_m / target_n  in  DIM_W each  rows / cols.
REQ-012 target_slot  in  SLOT_W  destination slot.
REQ-013 rand_bits  in  5  number of random low bits kept, 1..DATA_W.
REQ-014 fill_val  in  DATA_W  CONST-mode value.
REQ-015 gen_slot_idx, gen_row, gen_col, gen_data, gen_we  out  SLOT_W/DIM_W/DIM_W/DATA_W/1  element write port.
REQ-016 gen_dim_m, gen_dim_n, gen_dim_we  out  DIM_W/DIM_W/1  dimension write port.
REQ-017 busy, done, err  out  1 each  status.

Function
REQ-018 FSM states: IDLE, WRITE_DIM, FILL. All inputs are latched when start is accepted.
REQ-019 Start accepted at edge E0 with legal dims (1..MAX_DIM): gen_dim_we high for exactly one cycle after E1.
REQ-020 Element k (row-major, k=0..m*n-1) is written with gen_we high for the cycle after edge E(2+k), at gen_row=k/n, gen_col=k%n.
REQ-021 done pulses for one cycle, concurrent with the last gen_we; FSM returns to IDLE on that edge; a new start is accepted the next cycle.
REQ-022 busy is high from the cycle after E0 through the done cycle inclusive.
REQ-023 Illegal dims (m or n equal 0 or greater than MAX_DIM): err pulses for one cycle after E0; no dim or element writes; stays IDLE; LFSR unchanged.
REQ-024 start while busy is ignored; start held high after done starts a new job.
REQ-025 abort high in WRITE_DIM or FILL: no write in the following cycle, return to IDLE, no done, no err; abort in IDLE has no effect.
REQ-026 RANDOM: gen_data = lfsr[rand_bits-1:0] zero-extended; rand_bits 0 is treated as 1 and values above DATA_W as DATA_W.
REQ-027 LFSR: 16-bit Fibonacci, taps 15,13,12,10, shifting left with feedback into bit 0; advances only on RANDOM writes; state persists across jobs.
REQ-028 ZERO writes 0; IDENTITY writes 1 where row==col, else 0; CONST writes fill_val.
REQ-029 gen_we, gen_dim_we, done and err are single-cycle pulses; the other outputs hold their last values.

Reset
REQ-030 rst_n low: state IDLE, lfsr=LFSR_SEED, and every output 0, including busy, done and err.
REQ-031 Reset mid-job aborts immediately; no further writes occur after release until a new start.

Configuration
REQ-032 MATRIX_FILL_SEED_LOAD_EN defined: adds ports seed_we (in, 1) and seed_in (in, 16); seed_we in IDLE loads lfsr on the next edge; seed_in==0 loads LFSR_SEED instead; seed_we while busy is ignored.
REQ-033 MATRIX_FILL_SEED_LOAD_EN undefined: those ports are absent, and the seed comes only from reset.

Structure
REQ-034 Package matrix_fill_pkg SHALL hold the mode enum, the FSM state encoding, and the LFSR tap and default-seed constants.
REQ-035 Sub-module matrix_lfsr (16-bit register with advance, load and seed ports) SHALL be instantiated once.

Verification
REQ-036 RANDOM 2x2, rand_bits=4, slot 1, after reset -> dim_we (2,2); writes (0,0)=0x1, (0,1)=0x3, then two more writes; done with the fourth write; busy is 6 cycles.
REQ-037 IDENTITY 3x3 -> 9 writes: 1 at (0,0),(1,1),(2,2), 0 elsewhere; done on write 9; lfsr unchanged.
REQ-038 target_m=0, then target_n=6 (MAX_DIM=5) -> err pulse each time; no we activity; busy stays 0.
REQ-039 CONST 5x5, fill_val=0xBEEF, abort after the 3rd write -> exactly 3 writes; no done; the next start is accepted.
REQ-040 rst_n low mid-RANDOM job -> outputs 0 immediately; a rerun gives first element 0x1 again (seed restored).
REQ-041 With MATRIX_FILL_SEED_LOAD_EN: seed_in=0 then RANDOM 1x1, rand_bits=4 -> writes 0x1; seed_in=0x0002 -> writes 0x2.
